// File: rtl/eight_bit_subtractor.sv
// Registered unsigned subtractor: DIFF = A - B (mod 2^WIDTH) with borrow-out, one-cycle latency.
// Optional signed-overflow output OVF is enabled by defining SUB_SIGNED_OVF_EN.
module eight_bit_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW,
`ifdef SUB_SIGNED_OVF_EN
    output logic             OVF,
`endif
    output logic             out_valid
);

    logic [WIDTH-1:0] diff_next;
    logic [WIDTH:0]   borrow_chain;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;
    logic             valid_reg;

    assign borrow_chain[0] = 1'b0;

    // Ripple chain of full-subtractor cells; borrow propagates LSB to MSB.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign diff_next[gi]      = A[gi] ^ B[gi] ^ borrow_chain[gi];
            assign borrow_chain[gi+1] = (~A[gi] & B[gi])
                                      | (~(A[gi] ^ B[gi]) & borrow_chain[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                diff_reg   <= diff_next;
                borrow_reg <= borrow_chain[WIDTH];
            end
        end
    end

    assign DIFF      = diff_reg;
    assign BORROW    = borrow_reg;
    assign out_valid = valid_reg;

`ifdef SUB_SIGNED_OVF_EN
    logic ovf_next;
    logic ovf_reg;

    // Signed overflow only possible when operand signs differ.
    assign ovf_next = (A[WIDTH-1] ^ B[WIDTH-1]) & (diff_next[WIDTH-1] ^ A[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (in_valid) begin
            ovf_reg <= ovf_next;
        end
    end

    assign OVF = ovf_reg;
`endif

endmodule

// File: tb/tb_eight_bit_subtractor.sv
// Self-checking bench for eight_bit_subtractor using a scoreboard queue of expected results.
// Define SUB_SIGNED_OVF_EN to also exercise the OVF output.
module tb_eight_bit_subtractor;

    typedef struct packed {
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] DIFF;
    logic       BORROW;
    logic       out_valid;
    logic       dut_ovf;

    exp_t sb_q[$];
    exp_t last_exp;
    int   tests_run;
    int   tests_failed;

    eight_bit_subtractor #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .DIFF     (DIFF),
        .BORROW   (BORROW),
`ifdef SUB_SIGNED_OVF_EN
        .OVF      (dut_ovf),
`endif
        .out_valid(out_valid)
    );

`ifndef SUB_SIGNED_OVF_EN
    assign dut_ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of stimulus at the falling edge, record the expectation,
    // and return 1 time unit after the capturing rising edge.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic [8:0] full;
        @(negedge clk);
        in_valid = v;
        A        = a;
        B        = b;
        if (v) begin
            full     = {1'b0, a} - {1'b0, b};
            e.diff   = full[7:0];
            e.borrow = full[8];
`ifdef SUB_SIGNED_OVF_EN
            e.ovf    = (a[7] != b[7]) && (full[7] != a[7]);
`else
            e.ovf    = 1'b0;
`endif
            sb_q.push_back(e);
            last_exp = e;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        A        = 8'h14;
        B        = 8'h06;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            $display("[TB] reset edge %0d: v=%b b=%b d=%h", i, out_valid, BORROW, DIFF);
            if ({out_valid, BORROW, DIFF, dut_ovf} !== 11'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_hold[%0d]: got v=%b b=%b d=%h o=%b, want all 0",
                         i, out_valid, BORROW, DIFF, dut_ovf);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        sb_q.delete();
        last_exp = '0;
    endtask

    task automatic test_basic_back_to_back();
        logic [7:0] av[4] = '{8'h14, 8'h28, 8'h06, 8'h00};
        logic [7:0] bv[4] = '{8'h06, 8'h20, 8'h14, 8'hFF};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, av[i], bv[i]);
            e = sb_q.pop_front();
            tests_run++;
            $display("[TB] basic %h-%h: v=%b d=%h b=%b", av[i], bv[i], out_valid, DIFF, BORROW);
            if ({out_valid, BORROW, DIFF, dut_ovf} !== {1'b1, e.borrow, e.diff, e.ovf}) begin
                tests_failed++;
                $display("[TB] FAIL basic %h-%h: got v=%b b=%b d=%h o=%b, want v=1 b=%b d=%h o=%b",
                         av[i], bv[i], out_valid, BORROW, DIFF, dut_ovf, e.borrow, e.diff, e.ovf);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] av[3] = '{8'hFF, 8'h80, 8'h00};
        logic [7:0] bv[3] = '{8'h01, 8'h80, 8'h00};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, av[i], bv[i]);
            e = sb_q.pop_front();
            tests_run++;
            $display("[TB] boundary %h-%h: v=%b d=%h b=%b", av[i], bv[i], out_valid, DIFF, BORROW);
            if ({out_valid, BORROW, DIFF, dut_ovf} !== {1'b1, e.borrow, e.diff, e.ovf}) begin
                tests_failed++;
                $display("[TB] FAIL boundary %h-%h: got v=%b b=%b d=%h o=%b, want v=1 b=%b d=%h o=%b",
                         av[i], bv[i], out_valid, BORROW, DIFF, dut_ovf, e.borrow, e.diff, e.ovf);
            end
        end
    endtask

    task automatic test_hold_and_async_reset();
        exp_t e;
        step(1'b1, 8'h14, 8'h06);
        e = sb_q.pop_front();
        tests_run++;
        $display("[TB] hold load 14-06: v=%b d=%h b=%b", out_valid, DIFF, BORROW);
        if ({out_valid, BORROW, DIFF} !== {1'b1, 1'b0, 8'h0E} || e.diff !== 8'h0E) begin
            tests_failed++;
            $display("[TB] FAIL hold_load: got v=%b b=%b d=%h, want v=1 b=0 d=0e",
                     out_valid, BORROW, DIFF);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'hAA, 8'hBB);
            tests_run++;
            $display("[TB] hold idle %0d: v=%b d=%h b=%b", i, out_valid, DIFF, BORROW);
            if ({out_valid, BORROW, DIFF, dut_ovf} !== {1'b0, 1'b0, 8'h0E, last_exp.ovf}) begin
                tests_failed++;
                $display("[TB] FAIL hold_idle[%0d]: got v=%b b=%b d=%h o=%b, want v=0 b=0 d=0e o=%b",
                         i, out_valid, BORROW, DIFF, dut_ovf, last_exp.ovf);
            end
        end
        // Make outputs non-zero, then drop reset between edges.
        step(1'b1, 8'h06, 8'h14);
        e = sb_q.pop_front();
        tests_run++;
        if ({out_valid, BORROW, DIFF} !== {1'b1, e.borrow, e.diff}) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_load: got v=%b b=%b d=%h, want v=1 b=%b d=%h",
                     out_valid, BORROW, DIFF, e.borrow, e.diff);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        $display("[TB] async reset: v=%b d=%h b=%b", out_valid, DIFF, BORROW);
        if ({out_valid, BORROW, DIFF, dut_ovf} !== 11'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got v=%b b=%b d=%h o=%b, want all 0",
                     out_valid, BORROW, DIFF, dut_ovf);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        sb_q.delete();
        last_exp = '0;
    endtask

`ifdef SUB_SIGNED_OVF_EN
    task automatic test_ovf();
        logic [7:0] av[3] = '{8'h80, 8'h7F, 8'h05};
        logic [7:0] bv[3] = '{8'h01, 8'hFF, 8'h03};
        logic       ov[3] = '{1'b1, 1'b1, 1'b0};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, av[i], bv[i]);
            e = sb_q.pop_front();
            tests_run++;
            $display("[TB] ovf %h-%h: o=%b d=%h", av[i], bv[i], dut_ovf, DIFF);
            if (dut_ovf !== ov[i] || {out_valid, BORROW, DIFF} !== {1'b1, e.borrow, e.diff}) begin
                tests_failed++;
                $display("[TB] FAIL ovf %h-%h: got o=%b v=%b b=%b d=%h, want o=%b v=1 b=%b d=%h",
                         av[i], bv[i], dut_ovf, out_valid, BORROW, DIFF, ov[i], e.borrow, e.diff);
            end
        end
    endtask
`endif

    task automatic test_random();
        exp_t       e;
        logic       v;
        logic [7:0] a;
        logic [7:0] b;
        for (int i = 0; i < 1000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            a = 8'($urandom);
            b = 8'($urandom);
            step(v, a, b);
            tests_run++;
            if (v) begin
                e = sb_q.pop_front();
                $display("[TB] rand %0d valid %h-%h: d=%h b=%b o=%b", i, a, b, DIFF, BORROW, dut_ovf);
                if ({out_valid, BORROW, DIFF, dut_ovf} !== {1'b1, e.borrow, e.diff, e.ovf}) begin
                    tests_failed++;
                    $display("[TB] FAIL rand[%0d] %h-%h: got v=%b b=%b d=%h o=%b, want v=1 b=%b d=%h o=%b",
                             i, a, b, out_valid, BORROW, DIFF, dut_ovf, e.borrow, e.diff, e.ovf);
                end
            end else begin
                $display("[TB] rand %0d idle: d=%h b=%b v=%b", i, DIFF, BORROW, out_valid);
                if ({out_valid, BORROW, DIFF, dut_ovf} !==
                    {1'b0, last_exp.borrow, last_exp.diff, last_exp.ovf}) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_hold[%0d]: got v=%b b=%b d=%h o=%b, want v=0 b=%b d=%h o=%b",
                             i, out_valid, BORROW, DIFF, dut_ovf,
                             last_exp.borrow, last_exp.diff, last_exp.ovf);
                end
            end
        end
    endtask

    initial begin
        clk          = 1'b0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        A            = '0;
        B            = '0;
        last_exp     = '0;
        tests_run    = 0;
        tests_failed = 0;

        test_reset();
        test_basic_back_to_back();
        test_boundaries();
        test_hold_and_async_reset();
`ifdef SUB_SIGNED_OVF_EN
        test_ovf();
`endif
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/eight_bit_subtractor.md
Name: eight_bit_subtractor

Overview:
- Registered unsigned subtractor: DIFF = A - B (mod 2^WIDTH) with a borrow-out flag.
- Datapath is a ripple chain of 1-bit full-subtractor cells with borrow-in tied to 0.
- Result is captured in output registers one clock after a valid input.
- Used as a leaf arithmetic unit in datapaths that need a difference plus an A<B indication.

Parameters:
- WIDTH, 8, operand and result width in bits. The 8-bit configuration is the required, verified one; other values must elaborate correctly.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A and B are sampled on this clock edge when high.
- A  input  WIDTH  minuend, unsigned.
- B  input  WIDTH  subtrahend, unsigned.
- DIFF  output  WIDTH  registered (A - B) mod 2^WIDTH.
- BORROW  output  1  registered borrow-out; 1 iff A < B unsigned.
- out_valid  output  1  DIFF/BORROW updated on the previous edge.

Behaviour:
- Reset:
  - rst_n low asynchronously forces DIFF=0, BORROW=0, out_valid=0, regardless of clk.
  - Release is synchronous to the next rising edge.
- Combinational core, per bit i:
  - d_i = a_i ^ b_i ^ bin_i
  - bout_i = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i)
  - bin_0 = 0; bin_(i+1) = bout_i; BORROW = bout_(WIDTH-1).
- Latency:
  - On a rising edge with in_valid=1: DIFF/BORROW load the core result and out_valid goes to 1.
  - With in_valid=0: DIFF/BORROW hold their previous values and out_valid goes to 0.
- Throughput: one operation per cycle; back-to-back valid inputs produce back-to-back results. There is no backpressure.
- Arithmetic:
  - Operands and result are unsigned.
  - When A < B, DIFF is the two's-complement wrap, e.g. 6-20 gives 8'hF2 with BORROW=1.
  - A == B gives DIFF=0, BORROW=0.
  - A=0, B=2^WIDTH-1 gives DIFF=1, BORROW=1.
- Reset asserted mid-stream: any in-flight result is discarded and outputs return to reset values immediately.
- Inputs are don't-care while in_valid=0. The bench must still check that the outputs do not change in that case.

Optional Feature:
- Macro: SUB_SIGNED_OVF_EN
- When defined:
  - Adds output port OVF (1 bit), registered with the same timing, reset value and hold rules as BORROW.
  - OVF=1 iff signed two's-complement A - B overflows, i.e. sign(A) != sign(B) and sign(DIFF_core) != sign(A).
  - Example: 8'h80 - 8'h01 gives OVF=1.
- When not defined: port OVF does not exist, and all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, A=8'h14, B=8'h06 for several edges -> DIFF=0, BORROW=0, out_valid=0 throughout. Also assert rst_n low between clock edges -> outputs clear without waiting for a clock.
- Basic subtraction, applied back-to-back:
  - 8'b00010100 - 8'b00000110 -> DIFF=8'b00001110, BORROW=0.
  - 8'b00101000 - 8'b00100000 -> DIFF=8'b00001000, BORROW=0.
  - Each result appears one edge after its input with out_valid=1.
- Underflow: 8'b00000110 - 8'b00010100 -> DIFF=8'b11110010, BORROW=1. Also 8'h00 - 8'hFF -> DIFF=8'h01, BORROW=1.
- Boundaries:
  - 8'b11111111 - 8'b00000001 -> DIFF=8'b11111110, BORROW=0.
  - 8'b10000000 - 8'b10000000 -> DIFF=0, BORROW=0.
- Hold / reset mid-stream:
  - Valid 8'h14-8'h06, then in_valid=0 with A=8'hAA, B=8'hBB for 3 cycles -> DIFF stays 8'h0E, BORROW 0, out_valid 0.
  - Then pulse rst_n low -> immediate clear.
- Random: 1000 random valid/invalid cycles checked against the reference model {BORROW, DIFF} = {1'b0, A} - {1'b0, B}. With SUB_SIGNED_OVF_EN defined, also check OVF (e.g. 8'h80 - 8'h01 -> OVF=1; 8'h7F - 8'hFF -> OVF=1; 8'h05 - 8'h03 -> OVF=0).
